dqpsk_tx_sched: RTL and testbench

- Transmit-side symbol scheduler for the DQPSK modem. It sits between a byte source and the `diff_encode` block.
- Frames a burst as PREAMBLE → PAYLOAD → TAIL and splits each payload byte into dibits, MSB first.
- Paces one symbol every SYM_DIV clocks and holds the encoder in reset between frames.
- `diff_encode` advances every clock and treats dibit 2'b00 as "no phase change". The scheduler therefore presents a real dibit only on the strobe cycle and 2'b00 on all other cycles.

---
 rtl/dqpsk_tx_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_dqpsk_tx_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dqpsk_tx_sched.sv
// DQPSK transmit symbol scheduler: preamble/payload/tail framing, symbol pacing.
// Optional payload scrambler enabled by defining DQPSK_SCRAMBLE_EN.
module dqpsk_tx_sched #(
    parameter int unsigned SYM_DIV  = 8,
    parameter int unsigned PRE_LEN  = 16,
    parameter int unsigned TAIL_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] sym_data,
    output logic       sym_stb,
    output logic       enc_rstn,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_PAY,
        S_TAIL
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(SYM_DIV - 1);
    localparam logic [7:0] PRE_L    = 8'(PRE_LEN);
    localparam logic [7:0] TAIL_L   = 8'(TAIL_LEN);

    state_t     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [7:0] cnt_q, cnt_d;
    logic [9:0] dib_q, dib_d;
    logic [7:0] fetched_q, fetched_d;
    logic [7:0] len_q, len_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] left_q, left_d;
    logic       underrun_q, underrun_d;
    logic       done_q, done_d;

    logic       busy_w;
    logic       stb_w;
    logic       pend_w;
    logic       xfer_w;
    logic [1:0] dibit_w;
    logic [7:0] byte_w;

`ifdef DQPSK_SCRAMBLE_EN
    logic [6:0] lfsr_q, lfsr_d;
    logic [6:0] lfsr_nx;
    logic [7:0] mask_w;

    // x^7+x^6+1, output bit6, eight steps per byte
    always_comb begin
        lfsr_nx = lfsr_q;
        mask_w  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            mask_w[7-i] = lfsr_nx[6];
            lfsr_nx     = {lfsr_nx[5:0], lfsr_nx[6] ^ lfsr_nx[5]};
        end
    end

    assign byte_w = hold_q ^ mask_w;
`else
    assign byte_w = hold_q;
`endif

    assign busy_w = (state_q != S_IDLE);
    assign stb_w  = busy_w && (div_q == 8'd0);
    assign pend_w = busy_w && (div_q == DIV_LAST);

    always_comb begin
        in_ready = ((state_q == S_PRE) || (state_q == S_PAY)) &&
                   !hold_full_q && (fetched_q < len_q);
    end

    assign xfer_w = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        dib_d       = dib_q;
        fetched_d   = fetched_q;
        len_d       = len_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        left_d      = left_q;
        underrun_d  = underrun_q;
        done_d      = 1'b0;
        dibit_w     = 2'b00;
`ifdef DQPSK_SCRAMBLE_EN
        lfsr_d      = lfsr_q;
`endif
        if (busy_w) begin
            div_d = pend_w ? 8'd0 : div_q + 8'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                // done_q blocks a restart on the done cycle itself
                if (start && !done_q && (frame_len != 8'd0)) begin
                    state_d     = S_PRE;
                    len_d       = frame_len;
                    underrun_d  = 1'b0;
                    div_d       = 8'd0;
                    cnt_d       = 8'd0;
                    dib_d       = 10'd0;
                    fetched_d   = 8'd0;
                    hold_full_d = 1'b0;
                    left_d      = 2'd0;
`ifdef DQPSK_SCRAMBLE_EN
                    lfsr_d      = 7'h7F;
`endif
                end
            end
            S_PRE: begin
                if (stb_w) begin
                    dibit_w = 2'b11;
                    cnt_d   = cnt_q + 8'd1;
                end
                if (pend_w && (cnt_q == PRE_L)) begin
                    state_d = S_PAY;
                    cnt_d   = 8'd0;
                end
            end
            S_PAY: begin
                if (stb_w) begin
                    if (left_q == 2'd0) begin
                        if (hold_full_q) begin
                            dibit_w     = byte_w[7:6];
                            shift_d     = {byte_w[5:0], 2'b00};
                            left_d      = 2'd3;
                            hold_full_d = 1'b0;
                            dib_d       = dib_q + 10'd1;
`ifdef DQPSK_SCRAMBLE_EN
                            lfsr_d      = lfsr_nx;
`endif
                        end else begin
                            // late byte: idle symbol, slot retried next strobe
                            underrun_d = 1'b1;
                        end
                    end else begin
                        dibit_w = shift_q[7:6];
                        shift_d = {shift_q[5:0], 2'b00};
                        left_d  = left_q - 2'd1;
                        dib_d   = dib_q + 10'd1;
                    end
                end
                if (pend_w && (dib_q == {len_q, 2'b00})) begin
                    state_d = S_TAIL;
                end
            end
            S_TAIL: begin
                if (stb_w) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (pend_w && (cnt_q == TAIL_L)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (xfer_w) begin
            hold_d      = in_byte;
            hold_full_d = 1'b1;
            fetched_d   = fetched_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= 8'd0;
            cnt_q       <= 8'd0;
            dib_q       <= 10'd0;
            fetched_q   <= 8'd0;
            len_q       <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            shift_q     <= 8'd0;
            left_q      <= 2'd0;
            underrun_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef DQPSK_SCRAMBLE_EN
            lfsr_q      <= 7'h00;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            dib_q       <= dib_d;
            fetched_q   <= fetched_d;
            len_q       <= len_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            left_q      <= left_d;
            underrun_q  <= underrun_d;
            done_q      <= done_d;
`ifdef DQPSK_SCRAMBLE_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    assign sym_data = dibit_w;
    assign sym_stb  = stb_w;
    assign enc_rstn = busy_w;
    assign busy     = busy_w;
    assign done     = done_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_dqpsk_tx_sched.sv
// Directed bench for dqpsk_tx_sched with SYM_DIV=4, PRE_LEN=4, TAIL_LEN=2.
// Cycle 1 is the first cycle after the edge that accepts start.
module tb_dqpsk_tx_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] frame_len;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] sym_data;
    logic       sym_stb;
    logic       enc_rstn;
    logic       busy;
    logic       done;
    logic       underrun;

    int total = 0;
    int bad   = 0;

    int         stb_n;
    int         stb_cyc [64];
    logic [1:0] stb_dib [64];
    int         done_cyc;
    int         offnz;
    logic       u_at1;
    logic       u_end;

    logic [1:0] e1 [10] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10,
                            2'b11, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [1:0] e2 [15] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10,
                            2'b11, 2'b01, 2'b00, 2'b00, 2'b00,
                            2'b01, 2'b11, 2'b10, 2'b00, 2'b00};

    dqpsk_tx_sched #(
        .SYM_DIV (4),
        .PRE_LEN (4),
        .TAIL_LEN(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .frame_len(frame_len),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sym_data (sym_data),
        .sym_stb  (sym_stb),
        .enc_rstn (enc_rstn),
        .busy     (busy),
        .done     (done),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame; byte 2 becomes valid at cycle rel2 (0 = at once),
    // and a stray start with frame_len=3 is pulsed at cycle spur (0 = none).
    task automatic run_frame(input logic [7:0] len, input logic [7:0] b0,
                             input logic [7:0] b1, input int rel2,
                             input int spur);
        int   c;
        int   nb;
        logic xfer;
        stb_n    = 0;
        done_cyc = -1;
        offnz    = 0;
        u_at1    = 1'bx;
        u_end    = 1'bx;
        nb       = 0;
        in_byte  = b0;
        in_valid = 1'b1;
        start    = 1'b1;
        frame_len = len;
        step();
        c     = 1;
        start = 1'b0;
        while (c < 200) begin
            if (nb == 1 && rel2 != 0 && c >= rel2) in_valid = 1'b1;
            if (c == 1) u_at1 = underrun;
            if (sym_stb) begin
                stb_cyc[stb_n] = c;
                stb_dib[stb_n] = sym_data;
                stb_n++;
            end else if (sym_data !== 2'b00) begin
                offnz++;
            end
            if (done) begin
                done_cyc = c;
                u_end    = underrun;
                break;
            end
            if (c == spur) begin
                start     = 1'b1;
                frame_len = 8'd3;
            end else begin
                start = 1'b0;
            end
            xfer = in_valid && in_ready;
            step();
            c++;
            if (xfer) begin
                nb++;
                in_byte  = b1;
                in_valid = (nb == 1) && (rel2 == 0);
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        int dn;
        rst       = 1'b1;
        start     = 1'b0;
        frame_len = 8'd0;
        in_byte   = 8'd0;
        in_valid  = 1'b0;
        step();
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_sym_data", {30'd0, sym_data}, 32'd0);
        chk("rst_sym_stb", {31'd0, sym_stb}, 32'd0);
        chk("rst_enc_rstn", {31'd0, enc_rstn}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        rst = 1'b0;
        step();

        start     = 1'b1;
        frame_len = 8'd0;
        step();
        start = 1'b0;
        chk("len0_busy", {31'd0, busy}, 32'd0);
        chk("len0_enc_rstn", {31'd0, enc_rstn}, 32'd0);
        step();

        run_frame(8'd1, 8'hB4, 8'h00, 0, 0);
        chk("f1_nstb", stb_n, 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("f1_cyc%0d", i), stb_cyc[i], 1 + 4 * i);
            chk($sformatf("f1_dib%0d", i), {30'd0, stb_dib[i]},
                {30'd0, e1[i]});
        end
        chk("f1_done_cyc", done_cyc, 41);
        chk("f1_offstrobe", offnz, 0);
        chk("f1_underrun", {31'd0, u_end}, 32'd0);
        chk("f1_busy_after", {31'd0, busy}, 32'd0);
        chk("f1_enc_after", {31'd0, enc_rstn}, 32'd0);

        run_frame(8'd2, 8'hB4, 8'h1E, 35, 0);
        chk("f2_nstb", stb_n, 15);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("f2_cyc%0d", i), stb_cyc[i], 1 + 4 * i);
            chk($sformatf("f2_dib%0d", i), {30'd0, stb_dib[i]},
                {30'd0, e2[i]});
        end
        chk("f2_done_cyc", done_cyc, 61);
        chk("f2_underrun", {31'd0, u_end}, 32'd1);
        chk("f2_offstrobe", offnz, 0);

        run_frame(8'd1, 8'hB4, 8'h00, 0, 6);
        chk("f3_underrun_clr", {31'd0, u_at1}, 32'd0);
        chk("f3_nstb", stb_n, 10);
        chk("f3_done_cyc", done_cyc, 41);
        chk("f3_dib4", {30'd0, stb_dib[4]}, 32'd2);

        in_byte   = 8'hB4;
        in_valid  = 1'b1;
        start     = 1'b1;
        frame_len = 8'd1;
        step();
        start = 1'b0;
        for (int c = 1; c < 20; c++) step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mid_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_sym_data", {30'd0, sym_data}, 32'd0);
        chk("mid_sym_stb", {31'd0, sym_stb}, 32'd0);
        chk("mid_enc_rstn", {31'd0, enc_rstn}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_done", {31'd0, done}, 32'd0);
        dn = 0;
        for (int c = 0; c < 60; c++) begin
            if (done || busy) dn++;
            step();
        end
        chk("mid_no_done", dn, 0);

        run_frame(8'd1, 8'hB4, 8'h00, 0, 0);
        chk("f4_nstb", stb_n, 10);
        chk("f4_done_cyc", done_cyc, 41);
        chk("f4_dib6", {30'd0, stb_dib[6]}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
